// File: rtl/i2c_write_master_if.sv
// Handshake bundle between the audio-config sequencer and the I2C write engine.
// master: the I2C engine side; slave: the sequencer side.
interface i2c_write_master_if;
    logic [23:0] i2c_data;
    logic        go;
    logic        done;
    logic [2:0]  ack;
    logic        busy;

    modport master (input i2c_data, go, output done, ack, busy);
    modport slave  (output i2c_data, go, input done, ack, busy);
endinterface

// File: rtl/i2c_write_master.sv
// I2C write engine: START, three bytes MSB-first each followed by an ACK slot,
// then STOP. SCL is push-pull, SDA open-drain. Every bus phase lasts QCYC clocks.
// Optional build macro I2C_NACK_ABORT_EN: a NACK jumps straight to STOP and
// marks the skipped bytes as not acknowledged.
module i2c_write_master #(
    parameter int unsigned QCYC = 1
) (
    input  logic               clk_i2c,
    input  logic               reset,
    i2c_write_master_if.master cfg,
    output logic               i2c_sclk,
    inout  wire                i2c_sdat
);
    localparam int unsigned   QW    = $clog2(QCYC) + 1;
    localparam logic [QW-1:0] QLAST = QW'(QCYC - 1);

    typedef enum logic [2:0] {IDLE, START, BITS, ACK, STOP, DONE} state_t;
    state_t state, state_nxt;

    logic [QW-1:0] qcnt;
    logic [1:0]    phase;
    logic [2:0]    bit_cnt;
    logic [1:0]    byte_cnt;
    logic [23:0]   shreg;
    logic [2:0]    ack_r;
    logic          sda_low;
    logic          phase_end, slot_end, sample_pt;
    logic          abort;
    logic [2:0]    skip_mask;

    assign phase_end = (qcnt == QLAST);
    assign slot_end  = phase_end && (phase == 2'd3);
    assign sample_pt = phase_end && (phase == 2'd2);

`ifdef I2C_NACK_ABORT_EN
    logic ack_cur;
    // ACK sample of the current byte and the ack bits of the bytes that would be skipped
    always_comb begin
        case (byte_cnt)
            2'd0:    begin ack_cur = ack_r[2]; skip_mask = 3'b011; end
            2'd1:    begin ack_cur = ack_r[1]; skip_mask = 3'b001; end
            default: begin ack_cur = ack_r[0]; skip_mask = 3'b000; end
        endcase
    end
    assign abort = ack_cur;
`else
    assign abort     = 1'b0;
    assign skip_mask = '0;
`endif

    // State register
    always_ff @(posedge clk_i2c) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: phase/slot boundaries advance the transfer
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cfg.go) state_nxt = START;
            START:   if (phase_end && phase == 2'd1) state_nxt = BITS;
            BITS:    if (slot_end && bit_cnt == 3'd7) state_nxt = ACK;
            ACK:     if (slot_end) state_nxt = (byte_cnt == 2'd2 || abort) ? STOP : BITS;
            STOP:    if (phase_end && phase == 2'd2) state_nxt = DONE;
            DONE:    if (!cfg.go) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Phase timing, bit/byte sequencing, shift register and ACK capture
    always_ff @(posedge clk_i2c) begin
        if (reset) begin
            qcnt     <= '0;
            phase    <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
            ack_r    <= '0;
        end else if (state == IDLE || state == DONE) begin
            qcnt     <= '0;
            phase    <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            if (state == IDLE && cfg.go) begin
                shreg <= cfg.i2c_data;
                ack_r <= '0;
            end
        end else begin
            qcnt <= phase_end ? '0 : qcnt + 1'b1;
            // phase restarts at 0 on every state change, wraps 3->0 between bit slots
            if (phase_end) phase <= (state_nxt != state) ? 2'd0 : phase + 2'd1;
            if (state == BITS && slot_end) begin
                bit_cnt <= bit_cnt + 3'd1;
                shreg   <= {shreg[22:0], 1'b0};
            end
            if (state == ACK) begin
                if (sample_pt) begin
                    case (byte_cnt)
                        2'd0:    ack_r[2] <= i2c_sdat;
                        2'd1:    ack_r[1] <= i2c_sdat;
                        default: ack_r[0] <= i2c_sdat;
                    endcase
                end
                if (slot_end) begin
                    if (byte_cnt != 2'd2) byte_cnt <= byte_cnt + 2'd1;
                    if (abort) ack_r <= ack_r | skip_mask;
                end
            end
        end
    end

    // Bus levels and handshake outputs decoded from state and phase
    always_comb begin
        i2c_sclk = 1'b1;
        sda_low  = 1'b0;
        case (state)
            START: sda_low = (phase == 2'd1);
            BITS: begin
                i2c_sclk = (phase == 2'd1) || (phase == 2'd2);
                sda_low  = ~shreg[23];
            end
            ACK:   i2c_sclk = (phase == 2'd1) || (phase == 2'd2);
            STOP: begin
                i2c_sclk = (phase != 2'd0);
                sda_low  = (phase != 2'd2);
            end
            default: ;
        endcase
        cfg.done = (state == DONE);
        cfg.busy = (state != IDLE) && (state != DONE);
        cfg.ack  = ack_r;
    end

    assign i2c_sdat = sda_low ? 1'b0 : 1'bz;
endmodule

// File: tb/tb_i2c_write_master.sv
// Bench for i2c_write_master: sequencer handshake, ACK-ing slave model, bus
// decoder feeding a scoreboard, reset mid-transfer, and a QCYC=3 timing copy.
`timescale 1ns/1ps
module tb_i2c_write_master;
    logic clk_i2c = 1'b0;
    logic reset;
    always #5 clk_i2c = ~clk_i2c;

    i2c_write_master_if bus1();
    i2c_write_master_if bus3();
    logic sclk1, sclk3;
    wire  sda1, sda3;
    pullup (sda1);
    pullup (sda3);
    logic slave_drive = 1'b0;
    logic [2:0] slave_nack = 3'b000;
    assign sda1 = slave_drive ? 1'b0 : 1'bz;

    i2c_write_master #(.QCYC(1)) dut1 (
        .clk_i2c(clk_i2c), .reset(reset), .cfg(bus1), .i2c_sclk(sclk1), .i2c_sdat(sda1)
    );
    i2c_write_master #(.QCYC(3)) dut3 (
        .clk_i2c(clk_i2c), .reset(reset), .cfg(bus3), .i2c_sclk(sclk3), .i2c_sdat(sda3)
    );

`ifdef I2C_NACK_ABORT_EN
    localparam int unsigned CYC_N111 = 41;
    localparam int unsigned NB_N111  = 1;
    localparam int unsigned CYC_N010 = 77;
    localparam int unsigned NB_N010  = 2;
    localparam logic [2:0]  ACK_N010 = 3'b011;
    localparam int unsigned Q3_CYC   = 123;
`else
    localparam int unsigned CYC_N111 = 113;
    localparam int unsigned NB_N111  = 3;
    localparam int unsigned CYC_N010 = 113;
    localparam int unsigned NB_N010  = 3;
    localparam logic [2:0]  ACK_N010 = 3'b010;
    localparam int unsigned Q3_CYC   = 339;
`endif

    typedef struct {
        logic [23:0] data;
        logic [2:0]  nack;    // bytes the slave model refuses, bit2 = byte 0
        logic [2:0]  ack;     // expected ack output
        int unsigned cyc;     // expected edges from go acceptance to done
        int unsigned nbytes;  // bytes expected on the bus
    } vec_t;

    typedef struct {
        logic [23:0] data;
        logic [2:0]  nack;
        int unsigned nbytes;
    } exp_t;

    vec_t vecs[12];
    exp_t sbq[$];

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Bus decoder and ACK-ing slave on the QCYC=1 instance
    logic        prev_scl = 1'b1;
    logic        prev_sda = 1'b1;
    int unsigned nrise = 0;
    int unsigned n_start = 0;
    int unsigned n_stop = 0;
    logic [26:0] rx = '0;

    task automatic score();
        exp_t        e;
        logic [23:0] obs_d, msk;
        logic [2:0]  obs_a, amsk;
        if (sbq.size() == 0) begin
            n_total++;
            $display("FAIL sb_empty: STOP seen with no transfer expected");
            return;
        end
        e = sbq.pop_front();
        obs_d = {rx[26:19], rx[17:10], rx[8:1]};
        obs_a = {rx[18], rx[9], rx[0]};
        case (e.nbytes)
            1:       begin msk = 24'hFF0000; amsk = 3'b100; end
            2:       begin msk = 24'hFFFF00; amsk = 3'b110; end
            default: begin msk = 24'hFFFFFF; amsk = 3'b111; end
        endcase
        check("bus_data", obs_d & msk, e.data & msk);
        check("bus_ack", obs_a & amsk, e.nack & amsk);
    endtask

    always @(negedge clk_i2c) begin : mon1
        logic sda_now;
        sda_now = sda1;
        if (prev_scl && sclk1 && prev_sda && !sda_now) begin
            n_start++;
            nrise = 0;
            rx = '0;
        end else if (prev_scl && sclk1 && !prev_sda && sda_now) begin
            n_stop++;
            score();
        end else if (!prev_scl && sclk1) begin
            if (nrise < 27) rx[26 - nrise] = sda_now;
            nrise++;
        end else if (prev_scl && !sclk1) begin
            if (nrise % 9 == 8 && nrise < 27) slave_drive = !slave_nack[2 - nrise / 9];
            else slave_drive = 1'b0;
        end
        prev_scl = sclk1;
        prev_sda = sda_now;
    end

    // SCL run-length recorder on the QCYC=3 instance
    logic        prev3 = 1'b1;
    int unsigned run3 = 0;
    int unsigned nh = 0;
    int unsigned nl = 0;
    int unsigned hw[64];
    int unsigned lw[64];
    always @(negedge clk_i2c) begin : mon3
        if (sclk3 == prev3) run3++;
        else begin
            if (prev3) begin if (nh < 64) hw[nh] = run3; nh++; end
            else       begin if (nl < 64) lw[nl] = run3; nl++; end
            run3 = 1;
        end
        prev3 = sclk3;
    end

    // One sequencer command; entered and left at a negedge
    task automatic run_xfer(input vec_t v, input bit release_go);
        int unsigned cyc;
        exp_t e;
        bus1.i2c_data = v.data;
        bus1.go       = 1'b1;
        slave_nack    = v.nack;
        e.data = v.data; e.nack = v.nack; e.nbytes = v.nbytes;
        sbq.push_back(e);
        @(posedge clk_i2c);
        @(negedge clk_i2c);
        cyc = 0;
        check("busy_after_go", bus1.busy, 1);
        bus1.i2c_data = ~v.data;
        while (!bus1.done && cyc < 2000) begin
            @(posedge clk_i2c);
            @(negedge clk_i2c);
            cyc++;
        end
        check("done_cycles", cyc, v.cyc);
        check("ack_out", bus1.ack, v.ack);
        check("busy_at_done", bus1.busy, 0);
        if (release_go) begin
            bus1.go = 1'b0;
            @(posedge clk_i2c);
            @(negedge clk_i2c);
            check("done_clears", bus1.done, 0);
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int unsigned toggles, done_lo, cyc;
        logic        last;

        vecs[0]  = '{24'h340C00, 3'b000, 3'b000, 113, 3};
        vecs[1]  = '{24'h341E00, 3'b000, 3'b000, 113, 3};
        vecs[2]  = '{24'h340097, 3'b000, 3'b000, 113, 3};
        vecs[3]  = '{24'h340297, 3'b000, 3'b000, 113, 3};
        vecs[4]  = '{24'h340479, 3'b000, 3'b000, 113, 3};
        vecs[5]  = '{24'h340679, 3'b000, 3'b000, 113, 3};
        vecs[6]  = '{24'h340812, 3'b000, 3'b000, 113, 3};
        vecs[7]  = '{24'h340A06, 3'b000, 3'b000, 113, 3};
        vecs[8]  = '{24'h341201, 3'b000, 3'b000, 113, 3};
        vecs[9]  = '{24'h34ABCD, 3'b111, 3'b111, CYC_N111, NB_N111};
        vecs[10] = '{24'h3455AA, 3'b010, ACK_N010, CYC_N010, NB_N010};
        vecs[11] = '{24'h34F00F, 3'b001, 3'b001, 113, 3};

        reset = 1'b1;
        bus1.go = 1'b0; bus1.i2c_data = '0;
        bus3.go = 1'b0; bus3.i2c_data = '0;
        repeat (3) @(posedge clk_i2c);
        @(negedge clk_i2c);
        check("rst_sclk", sclk1, 1);
        check("rst_sda", sda1, 1);
        check("rst_done", bus1.done, 0);
        check("rst_busy", bus1.busy, 0);
        check("rst_ack", bus1.ack, 0);
        reset = 1'b0;

        // Back-to-back sequencer commands
        for (int unsigned i = 0; i < 12; i++) run_xfer(vecs[i], 1'b1);

        // go held high in DONE
        run_xfer(vecs[0], 1'b0);
        toggles = 0; done_lo = 0; last = sclk1;
        for (int unsigned i = 0; i < 20; i++) begin
            @(posedge clk_i2c);
            @(negedge clk_i2c);
            if (sclk1 != last) toggles++;
            last = sclk1;
            if (!bus1.done) done_lo++;
        end
        check("held_scl_toggles", toggles, 0);
        check("held_done_drops", done_lo, 0);
        bus1.go = 1'b0;
        @(posedge clk_i2c);
        @(negedge clk_i2c);
        check("held_done_clears", bus1.done, 0);

        // Reset during byte 1, bit 3 (phase 50, SCL low)
        bus1.i2c_data = 24'h340C00; bus1.go = 1'b1; slave_nack = 3'b000;
        @(posedge clk_i2c);
        repeat (50) @(posedge clk_i2c);
        @(negedge clk_i2c);
        check("mid_bus_level", {sclk1, sda1}, 2'b00);
        reset = 1'b1; bus1.go = 1'b0;
        @(posedge clk_i2c);
        @(negedge clk_i2c);
        reset = 1'b0;
        check("mid_rst_sclk", sclk1, 1);
        check("mid_rst_sda", sda1, 1);
        check("mid_rst_done", bus1.done, 0);
        check("mid_rst_busy", bus1.busy, 0);
        check("mid_rst_ack", bus1.ack, 0);
        run_xfer(vecs[1], 1'b1);

        // QCYC=3 instance, no slave present
        bus3.i2c_data = 24'h340C00; bus3.go = 1'b1;
        @(posedge clk_i2c);
        @(negedge clk_i2c);
        cyc = 0;
        while (!bus3.done && cyc < 5000) begin
            @(posedge clk_i2c);
            @(negedge clk_i2c);
            cyc++;
        end
        check("q3_done_cycles", cyc, Q3_CYC);
        check("q3_ack", bus3.ack, 3'b111);
        check("q3_first_slot_low", lw[0], 3);
        check("q3_scl_high_1", hw[1], 6);
        check("q3_scl_low_1", lw[1], 6);
        check("q3_scl_high_4", hw[4], 6);
        check("q3_scl_low_4", lw[4], 6);
        bus3.go = 1'b0;
        @(posedge clk_i2c);
        @(negedge clk_i2c);
        check("q3_done_clears", bus3.done, 0);

        check("start_count", n_start, 15);
        check("stop_count", n_stop, 14);
        check("sb_drained", sbq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
